// File: rtl/fosfor_present_ctrl_if.sv
// ============================================================================
// Module      : fosfor_present_ctrl_if
// Description : Control/status bundle between the PRESENT-80 round sequencer
//               and its surroundings (command decoder, key registers, state
//               datapath, register interface).
//   Start_i     : one-cycle start strobe
//   Abort_i     : synchronous abort
//   Key_ib      : 80-bit cipher key, sampled when a start is accepted
//   RoundKey_ob : current 64-bit round key
//   StateLoad_o : datapath loads the plaintext
//   RoundEn_o   : datapath performs one full round
//   FinalXor_o  : datapath performs the final key whitening
//   Round_ob    : current round counter
//   Busy_o      : operation in progress
//   Done_o      : one-cycle pulse, ciphertext valid
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fosfor_present_ctrl_if;
  logic        Start_i;
  logic        Abort_i;
  logic [79:0] Key_ib;
  logic [63:0] RoundKey_ob;
  logic        StateLoad_o;
  logic        RoundEn_o;
  logic        FinalXor_o;
  logic [4:0]  Round_ob;
  logic        Busy_o;
  logic        Done_o;

  // Controller side
  modport slave (
    input  Start_i, Abort_i, Key_ib,
    output RoundKey_ob, StateLoad_o, RoundEn_o, FinalXor_o,
           Round_ob, Busy_o, Done_o
  );

  // Driver / observer side
  modport master (
    output Start_i, Abort_i, Key_ib,
    input  RoundKey_ob, StateLoad_o, RoundEn_o, FinalXor_o,
           Round_ob, Busy_o, Done_o
  );
endinterface

`default_nettype wire

// File: rtl/fosfor_present_ctrl.sv
// ============================================================================
// Module      : fosfor_present_ctrl
// Description : Round sequencer and on-the-fly key scheduler for PRESENT-80.
//               Sequences LOAD -> ROUND x ROUNDS -> FINAL -> DONE and
//               advances the 80-bit key register once per ROUND cycle.
// Ports       :
//   Clk_k   : system clock, rising edge
//   Reset_r : asynchronous active-high reset
//   bus     : control/status bundle (slave modport), see interface header
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fosfor_present_ctrl #(
  parameter int ROUNDS = 31
) (
  input  logic                  Clk_k,
  input  logic                  Reset_r,
  fosfor_present_ctrl_if.slave  bus
);

  localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [79:0] key_reg;
  logic [79:0] key_next;
  logic [79:0] key_rot;
  logic [4:0]  round;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  // Next round key: rotate left by 61, S-box the top nibble, and mix the
  // current round counter into bits 19:15.
  always_comb begin
    key_rot         = {key_reg[18:0], key_reg[79:19]};
    key_next        = key_rot;
    key_next[79:76] = sbox(key_rot[79:76]);
    key_next[19:15] = key_rot[19:15] ^ round;
  end

  // Next-state logic; abort overrides everything, including a start in IDLE.
  always_comb begin
    state_nxt = state;
    if (bus.Abort_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.Start_i) state_nxt = LOAD;
        LOAD:    state_nxt = ROUND;
        ROUND:   if (round == LAST_ROUND) state_nxt = FINAL;
        FINAL:   state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk_k or posedge Reset_r) begin
    if (Reset_r) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Key register and round counter. Both only move when the FSM says so;
  // outside IDLE-accept and ROUND they retain their values, so the final
  // round key stays visible after DONE.
  always_ff @(posedge Clk_k or posedge Reset_r) begin
    if (Reset_r) begin
      key_reg <= '0;
      round   <= '0;
    end else if (!bus.Abort_i) begin
      case (state)
        IDLE: begin
          if (bus.Start_i) begin
            key_reg <= bus.Key_ib;
            round   <= 5'd1;
          end
        end
        ROUND: begin
          key_reg <= key_next;
          // Counter saturates at the last round; FINAL reuses that value.
          if (round != LAST_ROUND) begin
            round <= round + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // All outputs decode registered state only.
  assign bus.RoundKey_ob = key_reg[79:16];
  assign bus.Round_ob    = round;
  assign bus.StateLoad_o = (state == LOAD);
  assign bus.RoundEn_o   = (state == ROUND);
  assign bus.FinalXor_o  = (state == FINAL);
  assign bus.Busy_o      = (state == LOAD) || (state == ROUND) || (state == FINAL);
  assign bus.Done_o      = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_fosfor_present_ctrl.sv
// ============================================================================
// Module      : tb_fosfor_present_ctrl
// Description : Self-checking bench for fosfor_present_ctrl. A behavioural
//               PRESENT-80 model supplies round keys and ciphertexts; a small
//               state datapath driven by the controller strobes produces the
//               ciphertext that is compared against the model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fosfor_present_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fosfor_present_ctrl_if bus();

  fosfor_present_ctrl #(.ROUNDS(31)) dut (
    .Clk_k   (clk),
    .Reset_r (rst),
    .bus     (bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // ---------------- reference model ----------------
  logic [3:0]  sb [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                           4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  logic [63:0] mk [1:32];   // expected round keys K1..K32

  function automatic logic [63:0] sbox_layer(input logic [63:0] x);
    logic [63:0] y;
    for (int n = 0; n < 16; n++) y[n*4 +: 4] = sb[x[n*4 +: 4]];
    return y;
  endfunction

  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] y;
    for (int j = 0; j < 63; j++) y[(16 * j) % 63] = x[j];
    y[63] = x[63];
    return y;
  endfunction

  task automatic model_schedule(input logic [79:0] key);
    logic [79:0] k;
    k = key;
    for (int i = 1; i <= 32; i++) begin
      mk[i] = k[79:16];
      k = (k << 61) | (k >> 19);
      k[79:76] = sb[k[79:76]];
      k[19:15] = k[19:15] ^ 5'(i);
    end
  endtask

  function automatic logic [63:0] model_encrypt(input logic [63:0] pt);
    logic [63:0] s;
    s = pt;
    for (int i = 1; i <= 31; i++) s = p_layer(sbox_layer(s ^ mk[i]));
    return s ^ mk[32];
  endfunction

  // Expected {load,en,fx,busy,done,round,roundkey} for cycle c after start.
  function automatic logic [73:0] expect_cycle(input int c);
    if (c == 1)       return {5'b10010, 5'd1, mk[1]};
    else if (c <= 32) return {5'b01010, 5'(c - 1), mk[c - 1]};
    else if (c == 33) return {5'b00110, 5'd31, mk[32]};
    else if (c == 34) return {5'b00001, 5'd31, mk[32]};
    else              return {5'b00000, 5'd31, mk[32]};
  endfunction

  // ---------------- bench datapath ----------------
  logic [63:0] pt_val = '0;
  logic [63:0] dp     = '0;
  always @(posedge clk) begin
    if (bus.StateLoad_o)     dp <= pt_val;
    else if (bus.RoundEn_o)  dp <= p_layer(sbox_layer(dp ^ bus.RoundKey_ob));
    else if (bus.FinalXor_o) dp <= dp ^ bus.RoundKey_ob;
  end

  function automatic logic [73:0] observed();
    return {bus.StateLoad_o, bus.RoundEn_o, bus.FinalXor_o, bus.Busy_o,
            bus.Done_o, bus.Round_ob, bus.RoundKey_ob};
  endfunction

  // One operation. Called at a negedge; returns at a negedge.
  // stray_c / abort_c = 0 disables the corresponding injection.
  task automatic run_op(input string name, input logic [79:0] key,
                        input logic [63:0] pt, input int stray_c,
                        input int abort_c, input int ncyc,
                        input bit use_known, input logic [63:0] known_ct);
    logic [73:0] exp_v, obs_v;
    logic [63:0] ct_seen, ct_exp;
    model_schedule(key);
    pt_val      = pt;
    ct_seen     = '0;
    bus.Start_i = 1'b1;
    bus.Key_ib  = key;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      bus.Start_i = 1'b0;
      bus.Abort_i = 1'b0;
      bus.Key_ib  = {$urandom, $urandom, 16'($urandom)};
      exp_v = expect_cycle(c);
      obs_v = observed();
      total_cnt++;
      if (abort_c > 0 && c > abort_c) begin
        if (obs_v[73:69] !== 5'b00000) begin
          $display("FAIL %s abort cycle %0d: strobes got %b expected %b",
                   name, c, obs_v[73:69], 5'b00000);
        end else pass_cnt++;
      end else if (obs_v !== exp_v) begin
        $display("FAIL %s cycle %0d: got %h expected %h", name, c, obs_v, exp_v);
      end else pass_cnt++;
      if (c == 34) ct_seen = dp;
      if (c == stray_c) begin
        bus.Start_i = 1'b1;
        bus.Key_ib  = ~key;
      end
      if (c == abort_c) bus.Abort_i = 1'b1;
    end
    if (abort_c == 0) begin
      ct_exp = use_known ? known_ct : model_encrypt(pt);
      total_cnt++;
      if (ct_seen !== ct_exp) begin
        $display("FAIL %s ciphertext: got %h expected %h", name, ct_seen, ct_exp);
      end else pass_cnt++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total_cnt++;
      if (observed() !== 74'd0) begin
        $display("FAIL reset_idle cycle %0d: got %h expected %h", c, observed(), 74'd0);
      end else pass_cnt++;
    end
  endtask

  task automatic test_known_vectors();
    run_op("key0", 80'd0, 64'd0, 0, 0, 36, 1'b1, 64'h5579C1387B228445);
    run_op("key1", {80{1'b1}}, 64'd0, 0, 0, 36, 1'b1, 64'hE72C46C0F5945049);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      run_op("random", {$urandom, $urandom, 16'($urandom)},
             {$urandom, $urandom}, 0, 0, 35, 1'b0, 64'd0);
    end
  endtask

  task automatic test_stray_start();
    run_op("start_mid_run", {$urandom, $urandom, 16'($urandom)},
           {$urandom, $urandom}, 9, 0, 36, 1'b0, 64'd0);
    run_op("start_in_done", {$urandom, $urandom, 16'($urandom)},
           {$urandom, $urandom}, 34, 0, 37, 1'b0, 64'd0);
  endtask

  task automatic test_back_to_back();
    // ncyc=35 leaves the next start on the first IDLE cycle after DONE.
    run_op("b2b_a", {$urandom, $urandom, 16'($urandom)},
           {$urandom, $urandom}, 0, 0, 35, 1'b0, 64'd0);
    run_op("b2b_b", {$urandom, $urandom, 16'($urandom)},
           {$urandom, $urandom}, 0, 0, 36, 1'b0, 64'd0);
  endtask

  task automatic test_abort();
    run_op("abort", {$urandom, $urandom, 16'($urandom)},
           {$urandom, $urandom}, 0, 15, 40, 1'b0, 64'd0);
    // Abort has priority over a simultaneous start in IDLE.
    bus.Start_i = 1'b1;
    bus.Abort_i = 1'b1;
    @(negedge clk);
    bus.Start_i = 1'b0;
    bus.Abort_i = 1'b0;
    total_cnt++;
    if ({bus.StateLoad_o, bus.Busy_o} !== 2'b00) begin
      $display("FAIL abort_priority: got %b expected %b",
               {bus.StateLoad_o, bus.Busy_o}, 2'b00);
    end else pass_cnt++;
    run_op("after_abort", {$urandom, $urandom, 16'($urandom)},
           {$urandom, $urandom}, 0, 0, 35, 1'b0, 64'd0);
  endtask

  task automatic test_async_reset();
    model_schedule(80'd0);
    bus.Start_i = 1'b1;
    bus.Key_ib  = {$urandom, $urandom, 16'($urandom)};
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      bus.Start_i = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if (observed() !== 74'd0) begin
      $display("FAIL async_reset: got %h expected %h", observed(), 74'd0);
    end else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    total_cnt++;
    if (observed() !== 74'd0) begin
      $display("FAIL async_reset_hold: got %h expected %h", observed(), 74'd0);
    end else pass_cnt++;
    run_op("after_reset", 80'd0, 64'd0, 0, 0, 36, 1'b1, 64'h5579C1387B228445);
  endtask

  initial begin
    bus.Start_i = 1'b0;
    bus.Abort_i = 1'b0;
    bus.Key_ib  = '0;
    @(negedge clk);
    test_reset();
    test_known_vectors();
    test_random();
    test_stray_start();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
